// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: data width, receiver state encoding and
// the clocks-per-bit derivation used by both transmitter and receiver.
package uart_receiver_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_t;

  function automatic int uart_div(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

  function automatic int uart_half(input int clock_frequency, input int baud_rate);
    return uart_div(clock_frequency, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_input_synchronizer.sv
// Two-flop synchronizer for an asynchronous input; the reset value lets an
// idle-high line come out of reset without a spurious edge.
module uart_input_synchronizer #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta <= RESET_VALUE;
      r_sync <= RESET_VALUE;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: recovers frames from the serial line and presents each
// byte through a one-entry valid/ready buffer with framing/overrun pulses.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int BAUD_RATE       = 9600,
  parameter int CLOCK_FREQUENCY = 100000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  uart,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  framing_error,
  output logic                  overrun
);

  localparam int DIV  = uart_div(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int HALF = uart_half(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int CW   = $clog2(DIV + 1);
  localparam int IW   = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);

  logic                  w_rx;
  uart_state_t           r_state;
  logic [CW-1:0]         r_count;
  logic [IW-1:0]         r_bit_index;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_deliver;
  logic                  r_stop_error;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_framing_error;
  logic                  r_overrun;

  uart_input_synchronizer #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clock  (clock),
    .reset  (reset),
    .i_async(uart),
    .o_sync (w_rx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_bit_index  <= '0;
      r_shift      <= '0;
      r_deliver    <= 1'b0;
      r_stop_error <= 1'b0;
    end else begin
      r_deliver    <= 1'b0;
      r_stop_error <= 1'b0;
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (!w_rx) r_state <= START;
        end
        START: begin
          if (r_count == HALF_LAST) begin
            r_count     <= '0;
            r_bit_index <= '0;
            r_state     <= w_rx ? IDLE : DATA;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        DATA: begin
          if (r_count == DIV_LAST) begin
            r_shift     <= {w_rx, r_shift[DATA_WIDTH-1:1]};
            r_count     <= '0;
            r_bit_index <= r_bit_index + 1'b1;
            if (r_bit_index == BIT_LAST) r_state <= STOP;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        STOP: begin
          // Leaving at the stop-bit centre lets a back-to-back start edge be seen.
          if (r_count == DIV_LAST) begin
            r_count <= '0;
            if (w_rx) begin
              r_deliver <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_stop_error <= 1'b1;
              r_state      <= WAIT_HIGH;
            end
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        WAIT_HIGH: begin
          r_count <= '0;
          if (w_rx) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // r_shift stays stable for a full bit after the stop sample, so the
  // buffer can load it one cycle after r_deliver is raised.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data          <= '0;
      r_valid         <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_framing_error <= r_stop_error;
      r_overrun       <= 1'b0;
      if (r_deliver) begin
        if (!r_valid || ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data          = r_data;
  assign valid         = r_valid;
  assign framing_error = r_framing_error;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit: latency, glitch,
// framing/break, overrun, back-to-back, random stream and mid-frame reset.
module tb_uart_receiver;
  import uart_receiver_pkg::*;

  localparam int CF  = 16000000;
  localparam int BR  = 1000000;
  localparam int BIT = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       uart  = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       overrun;

  uart_receiver #(
    .BAUD_RATE(BR),
    .CLOCK_FREQUENCY(CF)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .uart         (uart),
    .data         (data),
    .valid        (valid),
    .ready        (ready),
    .framing_error(framing_error),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] got_q[$];
  int   valid_cycles = 0;
  int   fe_cnt = 0;
  int   ov_cnt = 0;
  int   rise_cyc = -1;
  int   ov_cyc = -1;
  logic prev_valid = 1'b0;

  always @(negedge clock) begin
    if (valid) valid_cycles++;
    if (valid && !prev_valid) rise_cyc = cyc;
    if (valid && ready) got_q.push_back(data);
    if (framing_error) fe_cnt++;
    if (overrun) begin
      ov_cnt++;
      ov_cyc = cyc;
    end
    prev_valid = valid;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_bit(input logic v, input int n);
    uart = v;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, output int t0);
    uart = 1'b0;
    t0 = cyc;
    tick(BIT);
    for (int i = 0; i < 8; i++) send_bit(b[i], BIT);
    send_bit(stop_v, BIT);
  endtask

  task automatic expect_byte(input string name, input logic [7:0] exp);
    if (got_q.size() == 0) begin
      check({name, "_present"}, 32'd0, 32'd1);
    end else begin
      check(name, {24'd0, got_q.pop_front()}, {24'd0, exp});
    end
  endtask

  initial begin
    int t0, t1, v0, fe0, ov0;
    logic [7:0] exp_q[$];
    logic [7:0] r;

    // Reset state
    tick(3);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_ferr", {31'd0, framing_error}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    tick(5);

    // 0xA5 with ready=1: latency and single-cycle valid
    v0 = valid_cycles;
    send_frame(8'hA5, 1'b1, t0);
    tick(20);
    check("a5_latency", rise_cyc - t0, 32'd156);
    check("a5_valid_cycles", valid_cycles - v0, 32'd1);
    expect_byte("a5_data", 8'hA5);
    check("a5_ferr", fe_cnt, 32'd0);
    check("a5_ovr", ov_cnt, 32'd0);

    // 4-cycle glitch then 0x5A
    v0 = valid_cycles;
    uart = 1'b0;
    tick(4);
    uart = 1'b1;
    tick(30);
    check("glitch_valid", valid_cycles - v0, 32'd0);
    check("glitch_ferr", fe_cnt, 32'd0);
    check("glitch_state", 32'(dut.r_state), 32'(IDLE));
    send_frame(8'h5A, 1'b1, t0);
    tick(20);
    expect_byte("5a_data", 8'h5A);

    // 0x3C with low stop bit, line held low, then 0x81
    send_frame(8'h3C, 1'b0, t0);
    tick(40);
    uart = 1'b1;
    tick(20);
    check("break_ferr", fe_cnt, 32'd1);
    check("break_no_byte", got_q.size(), 32'd0);
    send_frame(8'h81, 1'b1, t0);
    tick(20);
    expect_byte("81_data", 8'h81);
    check("81_ferr", fe_cnt, 32'd1);

    // Overrun with ready low
    ready = 1'b0;
    send_frame(8'h11, 1'b1, t0);
    tick(20);
    send_frame(8'h22, 1'b1, t1);
    tick(20);
    check("ovr_count", ov_cnt, 32'd1);
    check("ovr_cycle", ov_cyc - t1, 32'd156);
    check("ovr_valid", {31'd0, valid}, 32'd1);
    check("ovr_data", {24'd0, data}, 32'h11);
    check("ovr_no_hs", got_q.size(), 32'd0);
    ready = 1'b1;
    tick(3);
    expect_byte("ovr_hs", 8'h11);
    check("ovr_valid_drop", {31'd0, valid}, 32'd0);
    check("ovr_data_kept", {24'd0, data}, 32'h11);

    // Back-to-back 0x00, 0xFF, 0x7E
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t0);
    send_frame(8'h7E, 1'b1, t0);
    tick(20);
    check("b2b_count", got_q.size(), 32'd3);
    expect_byte("b2b_0", 8'h00);
    expect_byte("b2b_1", 8'hFF);
    expect_byte("b2b_2", 8'h7E);
    check("b2b_ferr", fe_cnt - fe0, 32'd0);
    check("b2b_ovr", ov_cnt - ov0, 32'd0);

    // Random back-to-back stream
    for (int i = 0; i < 32; i++) begin
      r = 8'($urandom_range(0, 255));
      exp_q.push_back(r);
      send_frame(r, 1'b1, t0);
    end
    tick(20);
    check("rand_count", got_q.size(), 32'd32);
    for (int i = 0; i < 32; i++) expect_byte("rand_data", exp_q[i]);

    // Reset during bit 4
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    uart = 1'b0;
    tick(BIT);
    for (int i = 0; i < 4; i++) send_bit(1'b0, BIT);
    send_bit(1'b0, BIT / 2);
    reset = 1'b1;
    uart = 1'b1;
    tick(2);
    check("mrst_valid", {31'd0, valid}, 32'd0);
    check("mrst_data", {24'd0, data}, 32'd0);
    check("mrst_state", 32'(dut.r_state), 32'(IDLE));
    reset = 1'b0;
    v0 = valid_cycles;
    tick(200);
    check("mrst_no_valid", valid_cycles - v0, 32'd0);
    check("mrst_no_ferr", fe_cnt - fe0, 32'd0);
    check("mrst_no_ovr", ov_cnt - ov0, 32'd0);
    send_frame(8'hC3, 1'b1, t0);
    tick(20);
    check("c3_latency", rise_cyc - t0, 32'd156);
    expect_byte("c3_data", 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver, the receive-side counterpart of the board UART transmitter. It samples the asynchronous `uart` input line and recovers 8N1-compatible frames (1 start bit, 8 data bits LSB-first, no parity, stop bit checked). It presents each received byte on a valid/ready handshake toward the fabric. It sits between the board's RX pin and the command/packet logic, and accepts frames sent with 1 or 2 stop bits.

## Interface
- `BAUD_RATE`, 9600: line bit rate.
- `CLOCK_FREQUENCY`, 100000000: `clock` frequency in Hz.

- `clock`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high; clock `clock`.
- `uart`  in  1  asynchronous serial line, idle high.
- `data`  out  8  received byte; stable while `valid` is high.
- `valid`  out  1  `data` holds an unconsumed byte.
- `ready`  in  1  consumer accepts `data` on a cycle where `valid && ready`.
- `framing_error`  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- `overrun`  out  1  one-cycle pulse: new byte completed while the buffer was full, new byte dropped.

## Operation
- `DIV = CLOCK_FREQUENCY / BAUD_RATE` (integer divide). `HALF = DIV / 2`. The counter is `$clog2(DIV+1)` bits wide.
- `uart` passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized value `rx`.
- FSM states:
  - IDLE: on `rx == 0`, go to START and clear the counter.
  - START: count to `HALF-1`, then sample `rx`.
    - `rx == 1`: glitch, return to IDLE.
    - `rx == 0`: clear the counter, clear the bit index, go to DATA.
  - DATA: count to `DIV-1`, then sample `rx` into the shift register (LSB first) and clear the counter. After the 8th sample, go to STOP.
  - STOP: count to `DIV-1`, then sample `rx`.
    - `rx == 1`: deliver the byte to the buffer, go to IDLE.
    - `rx == 0`: pulse `framing_error`, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx == 1`, then go to IDLE. A held-low line (break) never produces repeated frames.
- Output buffer, one entry:
  - Delivery with `!valid`, or with `valid && ready` in the same cycle: load `data`, set `valid`. No overrun.
  - Delivery with `valid && !ready`: keep the old `data`, pulse `overrun`.
  - `valid && ready` with no delivery: clear `valid` next cycle. `data` keeps its last value.
- Only the first stop bit is checked. A second stop bit is treated as idle.

## Timing
- Reset values: `valid=0`, `data=0`, `framing_error=0`, `overrun=0`, FSM in IDLE, counter and bit index 0, synchronizer flops 1.
- Reset mid-frame aborts the frame with no `valid`, `framing_error` or `overrun` pulse. The next start edge after reset is received normally.
- Latency from the falling start edge on `uart` to `valid` high: 2 cycles (sync) + 1 cycle (IDLE detect) + `HALF` + `9*DIV` cycles + 1 cycle (register). Data bits are sampled at bit centre ±1 cycle.
- `valid` rises 1 cycle after the stop sample. It stays high until the cycle after a `valid && ready` handshake.
- `framing_error` and `overrun` are high for exactly one cycle, registered 1 cycle after the stop sample.
- Back-to-back frames with a single stop bit are received with no lost bytes. The FSM returns to IDLE half a bit before the stop bit ends.

## Structure
- Shared UART header/package holds: data width (8), the state encoding (IDLE, START, DATA, STOP, WAIT_HIGH), and the `DIV`/`HALF` derivation macro used by both transmitter and receiver.
- One sub-module: `uart_input_synchronizer` (2-flop, parameterised reset value). Everything else stays in `uart_receiver`.

## Test plan
Use `CLOCK_FREQUENCY=16000000`, `BAUD_RATE=1000000` (`DIV=16`, `HALF=8`).
- Receive `0xA5`, 1 stop bit, `ready=1` -> `valid` high for exactly 1 cycle, `data=0xA5`, no error pulses. Check latency = 3+8+144+1 cycles from the falling edge.
- Low pulse of 4 cycles on an idle line -> no `valid`, no `framing_error`, FSM back to IDLE. A following `0x5A` frame is received correctly.
- Send `0x3C` with stop bit 0, line held low 40 more cycles, then high, then `0x81` -> one `framing_error` pulse, no `valid` for `0x3C`, then `data=0x81` valid.
- `ready=0`, send `0x11` then `0x22` -> `data=0x11` with `valid` held, one `overrun` pulse at the `0x22` stop sample. Raise `ready` -> `0x11` handshaken, `valid` drops.
- Back-to-back `0x00`, `0xFF`, `0x7E` with 1 stop bit and `ready=1` -> three `valid` pulses in order, no errors. Repeat with `uart` driven by `uart_transmitter` (same parameters) for 256 random bytes -> byte-exact match.
- Assert `reset` during bit 4 of a frame -> outputs at reset values, no pulses. The next frame `0xC3` is received correctly.
